// File: rtl/spinner_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spinner_quad_decoder
// Description : Quadrature A/B decoder for the spinner/paddle input path:
//               synchronizer, per-phase glitch filter, registered decode to
//               an 8-bit position with step/error pulses and activity flag.
// Revision    : 1.0 - initial release
// ============================================================================
module spinner_quad_decoder #(
  parameter int          FILTER_LEN = 4,
  parameter int          STEP_SHIFT = 0,
  parameter bit          CLAMP      = 1'b1,
  parameter logic [7:0]  CENTER     = 8'h80,
  parameter logic [15:0] ACT_TICKS  = 16'd6000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       center,
  output logic [7:0] pos,
  output logic       step_up,
  output logic       step_dn,
  output logic       err,
  output logic       active
);

  localparam logic [3:0]        c_filt_last = 4'(FILTER_LEN - 1);
  localparam logic signed [3:0] c_acc_lim   = 4'(1 << STEP_SHIFT);

  logic [1:0]        r_sync_a;
  logic [1:0]        r_sync_b;
  logic [1:0]        r_settle;
  logic              r_armed;
  logic              w_sync [2];
  logic              r_filt [2];
  logic [3:0]        r_cnt  [2];
  logic [1:0]        w_sync_pair;
  logic [1:0]        w_filt;
  logic [1:0]        r_prev;
  logic [1:0]        w_diff;
  logic              w_settled;
  logic              w_arm;
  logic              w_q_up;
  logic              w_q_dn;
  logic              w_illegal;
  logic signed [3:0] r_acc;
  logic signed [3:0] w_acc_sum;
  logic              w_hit_up;
  logic              w_hit_dn;
  logic [7:0]        r_pos;
  logic [7:0]        w_pos_next;
  logic              r_step_up;
  logic              r_step_dn;
  logic              r_err;
  logic [15:0]       r_timer;

  // Position of an {A,B} pair along the forward sequence 00,10,11,01.
  function automatic logic [1:0] f_gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync_a <= 2'b00;
      r_sync_b <= 2'b00;
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[0], enc_a};
      r_sync_b <= {r_sync_b[0], enc_b};
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      if (w_arm) r_armed <= 1'b1;
    end
  end

  assign w_sync[1]   = r_sync_a[1];
  assign w_sync[0]   = r_sync_b[1];
  assign w_sync_pair = {r_sync_a[1], r_sync_b[1]};
  assign w_filt      = {r_filt[1], r_filt[0]};
  // Arming waits until the synchronizer holds post-reset samples.
  assign w_settled   = (r_settle == 2'd2);
  assign w_arm       = ce && !r_armed && w_settled;

  for (genvar i = 0; i < 2; i++) begin : g_phase
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_filt[i] <= 1'b0;
        r_cnt[i]  <= 4'd0;
      end else if (w_arm) begin
        r_filt[i] <= w_sync[i];
        r_cnt[i]  <= 4'd0;
      end else if (ce && r_armed) begin
        if (w_sync[i] == r_filt[i]) begin
          r_cnt[i] <= 4'd0;
        end else if (r_cnt[i] == c_filt_last) begin
          r_filt[i] <= w_sync[i];
          r_cnt[i]  <= 4'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_diff    = f_gray_idx(w_filt) - f_gray_idx(r_prev);
  assign w_q_up    = r_armed && (w_diff == 2'd1);
  assign w_q_dn    = r_armed && (w_diff == 2'd3);
  assign w_illegal = r_armed && (w_diff == 2'd2);

  always_comb begin
    w_acc_sum = r_acc;
    if (w_q_up)      w_acc_sum = r_acc + 4'sd1;
    else if (w_q_dn) w_acc_sum = r_acc - 4'sd1;
  end

  assign w_hit_up = (w_acc_sum == c_acc_lim);
  assign w_hit_dn = (w_acc_sum == -c_acc_lim);

  always_comb begin
    w_pos_next = r_pos;
    if (w_hit_up) begin
      if (!(CLAMP && r_pos == 8'hFF)) w_pos_next = r_pos + 8'd1;
    end else if (w_hit_dn) begin
      if (!(CLAMP && r_pos == 8'h00)) w_pos_next = r_pos - 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_prev    <= 2'b00;
      r_acc     <= 4'sd0;
      r_pos     <= CENTER;
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      r_err     <= 1'b0;
      r_timer   <= 16'd0;
    end else begin
      if (w_arm)        r_prev <= w_sync_pair;
      else if (r_armed) r_prev <= w_filt;
      r_step_up <= w_hit_up && !center;
      r_step_dn <= w_hit_dn && !center;
      r_err     <= w_illegal;
      if (center) begin
        r_pos <= CENTER;
        r_acc <= 4'sd0;
      end else begin
        r_pos <= w_pos_next;
        r_acc <= (w_hit_up || w_hit_dn) ? 4'sd0 : w_acc_sum;
      end
      if (w_q_up || w_q_dn)            r_timer <= ACT_TICKS;
      else if (ce && r_timer != 16'd0) r_timer <= r_timer - 16'd1;
    end
  end

  assign pos     = r_pos;
  assign step_up = r_step_up;
  assign step_dn = r_step_dn;
  assign err     = r_err;
  assign active  = (r_timer != 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_spinner_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spinner_quad_decoder
// Description : Bench for spinner_quad_decoder in two configurations
//               (full-step clamping, quarter-step x4 wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spinner_quad_decoder;

  localparam logic [15:0] ACT = 16'd40;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ce      = 1'b0;
  logic       enc_a   = 1'b1;
  logic       enc_b   = 1'b1;
  logic       center  = 1'b0;
  logic [7:0] pos0, pos1;
  logic       up0, dn0, err0, act0, up1, dn1, err1, act1;

  spinner_quad_decoder #(.FILTER_LEN(4), .STEP_SHIFT(0), .CLAMP(1'b1),
                         .CENTER(8'h80), .ACT_TICKS(ACT)) u_dut0 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b),
    .center(center), .pos(pos0), .step_up(up0), .step_dn(dn0), .err(err0),
    .active(act0));

  spinner_quad_decoder #(.FILTER_LEN(4), .STEP_SHIFT(2), .CLAMP(1'b0),
                         .CENTER(8'h80), .ACT_TICKS(ACT)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b),
    .center(center), .pos(pos1), .step_up(up1), .step_dn(dn1), .err(err1),
    .active(act1));

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [1:0] ab;
    int         ticks;
    logic [7:0] pos0;
    logic [7:0] pos1;
  } vec_t;

  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  vec_t       vecs [$];

  int   n_vec = 0, n_bad = 0, cyc = 0, ce_mode = 0, ph = 0;
  logic last_ce = 1'b0;
  int   cnt_up [2], cnt_dn [2], cnt_err [2];
  bit   act_seen;

  // Reference model state (filter front end is shared by both configs)
  logic [1:0] m_s1, m_s2, m_filt, m_prev;
  int         m_settle, m_cnt [2];
  bit         m_armed;
  int         m_acc [2], m_pos [2], m_timer [2];
  bit         m_up [2], m_dn [2], m_err [2];

  function automatic int gidx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gray[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [1:0] syn;
    int d, lim;
    syn = m_s2;
    if (reset) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_settle = 0; m_armed = 0;
      m_filt = 2'b00; m_prev = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_pos[k] = 128; m_timer[k] = 0;
        m_up[k] = 0; m_dn[k] = 0; m_err[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 1 : 4;
      m_up[k] = 0; m_dn[k] = 0; m_err[k] = 0;
      d = m_armed ? (gidx(m_filt) - gidx(m_prev) + 4) % 4 : 0;
      if (d == 2) m_err[k] = 1;
      if (d == 1 || d == 3) begin
        m_timer[k] = int'(ACT);
        m_acc[k] += (d == 1) ? 1 : -1;
        if (m_acc[k] == lim) begin
          m_acc[k] = 0; m_up[k] = 1;
          m_pos[k] = (k == 0) ? ((m_pos[k] == 255) ? 255 : m_pos[k] + 1) : (m_pos[k] + 1) % 256;
        end else if (m_acc[k] == -lim) begin
          m_acc[k] = 0; m_dn[k] = 1;
          m_pos[k] = (k == 0) ? ((m_pos[k] == 0) ? 0 : m_pos[k] - 1) : (m_pos[k] + 255) % 256;
        end
      end else if (ce && m_timer[k] > 0) begin
        m_timer[k]--;
      end
      if (center) begin
        m_pos[k] = 128; m_acc[k] = 0; m_up[k] = 0; m_dn[k] = 0;
      end
    end
    if (ce && !m_armed && m_settle >= 2) begin
      m_filt = syn; m_prev = syn; m_armed = 1;
    end else if (m_armed) begin
      m_prev = m_filt;
      if (ce) begin
        for (int b = 0; b < 2; b++) begin
          if (syn[b] == m_filt[b]) m_cnt[b] = 0;
          else begin
            m_cnt[b]++;
            if (m_cnt[b] == 4) begin m_filt[b] = syn[b]; m_cnt[b] = 0; end
          end
        end
      end
    end
    if (m_settle < 2) m_settle++;
    m_s2 = m_s1;
    m_s1 = {enc_a, enc_b};
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_out(input int k, input logic [11:0] got);
    logic [11:0] want;
    want = {8'(m_pos[k]), m_up[k], m_dn[k], m_err[k], (m_timer[k] != 0)};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL model_cmp dut%0d cycle %0d: {pos,up,dn,err,active} got %h expected %h",
               k, cyc, got, want);
    end
  endtask

  task automatic tick();
    case (ce_mode)
      0:       ce = (cyc % 4 == 3);
      1:       ce = 1'b1;
      default: ce = ($urandom_range(0, 2) == 0);
    endcase
    last_ce = ce;
    @(posedge clk_sys);
    model_step();
    #1;
    chk_out(0, {pos0, up0, dn0, err0, act0});
    chk_out(1, {pos1, up1, dn1, err1, act1});
    cnt_up[0] += int'(up0); cnt_dn[0] += int'(dn0); cnt_err[0] += int'(err0);
    cnt_up[1] += int'(up1); cnt_dn[1] += int'(dn1); cnt_err[1] += int'(err1);
    if (act0 || act1) act_seen = 1;
    cyc++;
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin cnt_up[k] = 0; cnt_dn[k] = 0; cnt_err[k] = 0; end
    act_seen = 0;
  endtask

  task automatic fwd();
    ph = (ph + 1) % 4;
    {enc_a, enc_b} = gray[ph];
    repeat (8) tick();
  endtask

  initial begin
    int n;
    bit found;
    clr();
    // Steady 11 through reset: no counts, no activity
    repeat (5) tick();
    reset = 1'b0;
    clr();
    repeat (100) tick();
    chk("rst_pos0", pos0, 8'h80);
    chk("rst_pos1", pos1, 8'h80);
    chk("rst_quiet", cnt_up[0] + cnt_dn[0] + cnt_err[0] + cnt_up[1] + cnt_dn[1] + cnt_err[1] + int'(act_seen), 0);

    // Reset mid-operation while the inputs move to 00
    reset = 1'b1;
    repeat (3) tick();
    {enc_a, enc_b} = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    clr();
    repeat (40) tick();
    chk("rst2_quiet", cnt_up[0] + cnt_dn[0] + cnt_err[0] + int'(act_seen), 0);

    vecs.push_back('{2'b10, 8, 8'h81, 8'h80});
    vecs.push_back('{2'b11, 8, 8'h82, 8'h80});
    vecs.push_back('{2'b01, 8, 8'h83, 8'h80});
    vecs.push_back('{2'b00, 8, 8'h84, 8'h81});
    vecs.push_back('{2'b01, 8, 8'h83, 8'h81});
    vecs.push_back('{2'b11, 8, 8'h82, 8'h81});
    vecs.push_back('{2'b10, 8, 8'h81, 8'h81});
    vecs.push_back('{2'b00, 8, 8'h80, 8'h80});
    vecs.push_back('{2'b10, 8, 8'h81, 8'h80});
    vecs.push_back('{2'b11, 8, 8'h82, 8'h80});
    vecs.push_back('{2'b01, 8, 8'h83, 8'h80});
    vecs.push_back('{2'b11, 8, 8'h82, 8'h80});
    vecs.push_back('{2'b10, 8, 8'h81, 8'h80});
    vecs.push_back('{2'b00, 8, 8'h80, 8'h80});
    vecs.push_back('{2'b10, 8, 8'h81, 8'h80});
    vecs.push_back('{2'b11, 8, 8'h82, 8'h80});
    vecs.push_back('{2'b01, 8, 8'h83, 8'h80});
    vecs.push_back('{2'b00, 8, 8'h84, 8'h81});
    clr();
    foreach (vecs[i]) begin
      {enc_a, enc_b} = vecs[i].ab;
      repeat (vecs[i].ticks * 4) tick();
      chk($sformatf("vec%0d_pos0", i), pos0, vecs[i].pos0);
      chk($sformatf("vec%0d_pos1", i), pos1, vecs[i].pos1);
      chk($sformatf("vec%0d_active", i), act0, 1);
    end
    chk("tbl_up0", cnt_up[0], 11);
    chk("tbl_dn0", cnt_dn[0], 7);
    chk("tbl_up1", cnt_up[1], 2);
    chk("tbl_dn1", cnt_dn[1], 1);
    chk("tbl_err", cnt_err[0] + cnt_err[1], 0);
    ph = 0;

    // Activity window measured from a single step pulse
    ph = 1;
    {enc_a, enc_b} = gray[ph];
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (up0) begin found = 1; break; end
    end
    chk("act_step_seen", int'(found), 1);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (last_ce) n++;
      if (!act0) break;
    end
    chk("act_ticks", n, int'(ACT));
    chk("act_fell", act0, 0);

    // Three-tick glitch on A is rejected
    clr();
    enc_a = ~enc_a;
    repeat (12) tick();
    enc_a = ~enc_a;
    repeat (40) tick();
    chk("glitch_active", int'(act_seen), 0);
    chk("glitch_pulses", cnt_up[0] + cnt_dn[0] + cnt_err[0], 0);
    chk("glitch_pos0", pos0, 8'h85);

    // Illegal 00->11, then legal 11->01
    {enc_a, enc_b} = 2'b00;
    repeat (32) tick();
    chk("ill_pre_pos0", pos0, 8'h84);
    clr();
    {enc_a, enc_b} = 2'b11;
    repeat (32) tick();
    chk("ill_err0", cnt_err[0], 1);
    chk("ill_err1", cnt_err[1], 1);
    chk("ill_pos0", pos0, 8'h84);
    chk("ill_steps0", cnt_up[0] + cnt_dn[0], 0);
    clr();
    {enc_a, enc_b} = 2'b01;
    repeat (32) tick();
    chk("ill_next_up0", cnt_up[0], 1);
    chk("ill_next_pos0", pos0, 8'h85);
    {enc_a, enc_b} = 2'b00;
    repeat (32) tick();
    ph = 0;

    // Saturation (dut0) and wrap (dut1) with ce every cycle
    ce_mode = 1;
    for (int i = 0; i < 400 && m_pos[0] != 255; i++) fwd();
    chk("clamp_reach", pos0, 8'hFF);
    clr();
    repeat (2) fwd();
    chk("clamp_pos0", pos0, 8'hFF);
    chk("clamp_up0", cnt_up[0], 2);
    for (int i = 0; i < 1200 && m_pos[1] != 255; i++) fwd();
    chk("wrap_reach", pos1, 8'hFF);
    clr();
    repeat (4) fwd();
    chk("wrap_pos1", pos1, 8'h00);
    chk("wrap_up1", cnt_up[1], 1);

    // center coincides with the decode cycle of a step
    clr();
    ph = (ph + 1) % 4;
    {enc_a, enc_b} = gray[ph];
    repeat (6) tick();
    center = 1'b1;
    tick();
    center = 1'b0;
    repeat (4) tick();
    chk("ctr_pos0", pos0, 8'h80);
    chk("ctr_pos1", pos1, 8'h80);
    chk("ctr_nopulse", cnt_up[0] + cnt_dn[0] + cnt_up[1] + cnt_dn[1], 0);

    // Randomized traffic against the reference model
    ce_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4, 5: ph = (ph + 1) % 4;
          6:                ph = (ph + 3) % 4;
          default:          ph = $urandom_range(0, 3);
        endcase
        {enc_a, enc_b} = gray[ph];
      end
      center = ($urandom_range(0, 299) == 0);
      reset  = (i >= 1500 && i < 1503);
      tick();
    end
    center = 1'b0;
    reset  = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spinner_quad_decoder.md
# spinner_quad_decoder

Receive-side quadrature decoder for the arcade spinner/paddle path: takes raw A/B encoder phases (external encoder on user-port pins, or the quadrature produced by the joystick-to-quadrature encoder) and converts them into an 8-bit absolute paddle position plus per-step direction pulses. It sits between the input pins and the game core's paddle input, clocked on clk_sys. It provides synchronization, glitch filtering, illegal-transition detection and an activity flag, so the top level can auto-select between encoder and joystick sources.

## Interface
- FILTER_LEN, 4: consecutive ce ticks a phase must be stable before it is accepted; legal range 1..15.
- STEP_SHIFT, 0: quarter-steps per position step = 2^STEP_SHIFT; legal range 0..2.
- CLAMP, 1: 1 = pos saturates at 0/255; 0 = pos wraps modulo 256.
- CENTER, 8'h80: pos value at reset and on recenter.
- ACT_TICKS, 16'd6000: ce ticks that active stays high after the last valid transition.

- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  sample/filter tick enable, one clk_sys cycle wide.
- enc_a  in  1  raw phase A, asynchronous.
- enc_b  in  1  raw phase B, asynchronous.
- center  in  1  synchronous recenter request, level-sampled every clk_sys.
- pos  out  8  paddle position.
- step_up  out  1  one-cycle pulse per position step up.
- step_dn  out  1  one-cycle pulse per position step down.
- err  out  1  one-cycle pulse on an illegal (two-bit) transition.
- active  out  1  high while transitions have occurred within the last ACT_TICKS ce ticks.

## Operation
- Sync: enc_a/enc_b each pass through a 2-FF synchronizer on every clk_sys edge, independent of ce.
- Arming: the armed flag clears at reset. On the first ce tick with armed=0 occurring at least 2 cycles after reset deasserts, the filtered state is loaded directly from the synced pair, armed is set, and nothing is counted.
- Filter (armed, per phase): on each ce tick, if the synced value equals the filtered value, the stability counter clears. Otherwise the counter increments; when it reaches FILTER_LEN, the filtered value takes the synced value and the counter clears.
- Decode: compares the new filtered {A,B} with the previous one.
  - Up sequence (A leads): 00→10→11→01→00, +1 quarter-step.
  - Reverse sequence: -1 quarter-step.
  - Both bits changed: err pulse, no count, accumulator unchanged, previous state updated.
  - No change: nothing.
- Accumulator: signed, range ±(2^STEP_SHIFT−1).
  - Reaching +2^STEP_SHIFT produces a step_up and clears the accumulator.
  - Reaching −2^STEP_SHIFT produces a step_dn and clears the accumulator.
  - A direction reversal simply counts back toward 0.
- Position: step_up gives pos+1 and step_dn gives pos−1.
  - CLAMP=1: holds at 255 or 0; step pulses still fire (they report motion, not position).
  - CLAMP=0: wraps 255↔0.
- Recenter: center=1 sets pos←CENTER and clears the accumulator. If a step occurs in the same cycle, center wins and step_up/step_dn are suppressed for that cycle; err is not suppressed.
- Activity: every valid (±1) quarter-step reloads a 16-bit timer with ACT_TICKS. The timer decrements on ce when nonzero. active = (timer != 0). Illegal transitions do not reload the timer.

## Timing
- Reset values:
  - Outputs: pos=CENTER, step_up=0, step_dn=0, err=0, active=0.
  - Internal: armed=0, accumulator=0, filter counters=0, timer=0.
- Reset mid-operation: all state returns to reset values on the next edge and arming is repeated. Inputs held steady across reset produce no counts.
- Latency from a raw edge to filtered change: 2 clk_sys cycles for sync, then FILTER_LEN ce ticks of stability. The filtered register updates on the FILTER_LEN-th qualifying ce edge.
- Decode is registered: step_up/step_dn/err assert in the clk_sys cycle after the filtered change, for exactly 1 cycle. pos holds its new value from that same edge.
- At most one quarter-step is decoded per ce tick, so the maximum count rate is ce_rate/FILTER_LEN.
- active rises on the same edge as the first step's accumulator update, and falls ACT_TICKS ce ticks after the last valid transition.

## Test plan
- Reset with enc_a=enc_b=1 held for 100 cycles, ce every 4 cycles: pos=0x80, no step/err pulses, active=0 throughout.
- STEP_SHIFT=0, FILTER_LEN=4: drive 00→10→11→01→00, each phase held for 8 ce ticks → 4 step_up pulses, pos=0x84. Then reverse the sequence → 4 step_dn pulses, pos=0x80.
- STEP_SHIFT=2: 3 forward quarter-steps then 3 reverse → no step pulses, pos=0x80. Then 4 forward → one step_up, pos=0x81.
- Glitch: A pulses for 3 ce ticks with FILTER_LEN=4 → no count, no err, active stays 0.
- Illegal transition 00→11 → single err pulse, pos unchanged. Then 11→01 → step_up.
- Saturation and recenter:
  - CLAMP=1 at pos=255 with 2 more up steps → pos stays 255, 2 step_up pulses.
  - CLAMP=0 at pos=255 with 1 up step → pos=0.
  - center asserted on the same cycle as a step → pos=0x80, no pulse.
  - active drops exactly ACT_TICKS ce ticks after the last transition.
